// File: rtl/uart_tx_queue_pkg.sv
// Shared constants for the UART transmit queue: feeder FSM encodings
// and UART control/status register bit positions.
package uart_tx_queue_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_BUSY = 3'd2;
    localparam logic [2:0] S_REL  = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    localparam int UART_EN_BIT    = 0;
    localparam int UART_STRTX_BIT = 1;
    localparam int UART_TBUSY_BIT = 2;
    localparam int UART_RXNE_BIT  = 3;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Push/pop/status bundle between the queue controller and its FIFO.
interface uart_tx_queue_if #(
    parameter int W  = 8,
    parameter int AW = 4
);
    logic          push;
    logic          pop;
    logic          flush;
    logic [W-1:0]  wdata;
    logic [W-1:0]  rdata;
    logic          full;
    logic          empty;
    logic [AW:0]   count;

    modport master (
        output push, pop, flush, wdata,
        input  rdata, full, empty, count
    );

    modport slave (
        input  push, pop, flush, wdata,
        output rdata, full, empty, count
    );
endinterface

// File: rtl/uart_tx_queue_sync_fifo.sv
// Circular FIFO with registered full/empty flags and a synchronous flush.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    uart_tx_queue_if.slave fif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          do_push, do_pop;

    assign do_push = fif.push & ~full_q & ~fif.flush;
    assign do_pop  = fif.pop & ~empty_q & ~fif.flush;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (fif.flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wp_d = wp_q + 1'b1;
            if (do_pop)  rp_d = rp_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
        full_d  = (cnt_d == FULL_CNT);
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wp_q] <= fif.wdata;
    end

    assign fif.rdata = mem_q[rp_q];
    assign fif.full  = full_q;
    assign fif.empty = empty_q;
    assign fif.count = cnt_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue in front of a UART transmitter; a feeder FSM hands one
// byte at a time to the UART using its start/busy handshake.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_wr_en,
    input  logic [7:0]  i_wr_data,
    input  logic        i_ovf_clr,
    input  logic        i_busy_tx,
    output logic        o_str_tx,
    output logic [7:0]  o_data_tx,
    output logic        o_full,
    output logic        o_empty,
    output logic [AW:0] o_count,
    output logic        o_ovf,
    output logic        o_sent
);

    uart_tx_queue_if #(.W(8), .AW(AW)) fif ();

    sync_fifo #(
        .W     (8),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i  (i_clk),
        .rst_ni (i_rst),
        .fif    (fif.slave)
    );

    logic [2:0] state_q, state_d;
    logic       str_q, str_d;
    logic [7:0] data_q, data_d;
    logic       sent_q, sent_d;
    logic       ovf_q, ovf_d;
    logic       drop;

    assign fif.flush = ~i_en;
    assign fif.push  = i_en & i_wr_en;
    assign fif.wdata = i_wr_data;
    assign fif.pop   = i_en & (state_q == S_REL);

    // Full is the registered flag, so a pop in the same cycle cannot rescue a write.
    assign drop = i_en & i_wr_en & fif.full;

    always_comb begin
        if (drop)           ovf_d = 1'b1;
        else if (i_ovf_clr) ovf_d = 1'b0;
        else                ovf_d = ovf_q;
    end

    always_comb begin
        state_d = state_q;
        str_d   = str_q;
        data_d  = data_q;
        sent_d  = 1'b0;
        if (!i_en) begin
            state_d = S_IDLE;
            str_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fif.empty) begin
                        data_d  = fif.rdata;
                        str_d   = 1'b1;
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_busy_tx) state_d = S_BUSY;
                end
                S_BUSY: begin
                    if (!i_busy_tx) begin
                        state_d = S_REL;
                        str_d   = 1'b0;
                        sent_d  = 1'b1;
                    end
                end
                S_REL:   state_d = S_GAP;
                S_GAP:   state_d = S_IDLE;
                default: begin
                    state_d = S_IDLE;
                    str_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            str_q   <= 1'b0;
            data_q  <= 8'h00;
            sent_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            str_q   <= str_d;
            data_q  <= data_d;
            sent_q  <= sent_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_str_tx  = str_q;
    assign o_data_tx = data_q;
    assign o_sent    = sent_q;
    assign o_ovf     = ovf_q;
    assign o_full    = fif.full;
    assign o_empty   = fif.empty;
    assign o_count   = fif.count;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a simple UART busy-handshake model.
module tb_uart_tx_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       ovf_clr = 1'b0;
    logic       busy = 1'b0;
    logic       str_tx;
    logic [7:0] data_tx;
    logic       full, empty, ovf, sent;
    logic [4:0] count;

    int         total = 0;
    int         fails = 0;
    int         sent_cnt = 0;
    logic [7:0] rx_q [$];
    int         bcnt = 0;
    logic       done = 1'b0;

    always #5 clk = ~clk;

    uart_tx_queue #(.DEPTH(16), .AW(4)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_wr_en   (wr_en),
        .i_wr_data (wr_data),
        .i_ovf_clr (ovf_clr),
        .i_busy_tx (busy),
        .o_str_tx  (str_tx),
        .o_data_tx (data_tx),
        .o_full    (full),
        .o_empty   (empty),
        .o_count   (count),
        .o_ovf     (ovf),
        .o_sent    (sent)
    );

    // UART model: busy for 20 cycles after a start, then waits for start to drop.
    always @(posedge clk) begin
        if (!rst || !en) begin
            busy <= 1'b0;
            bcnt <= 0;
            done <= 1'b0;
        end else if (done) begin
            if (!str_tx) done <= 1'b0;
        end else if (busy) begin
            if (bcnt == 1) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            bcnt <= bcnt - 1;
        end else if (str_tx) begin
            busy <= 1'b1;
            bcnt <= 20;
        end
    end

    always @(posedge clk) begin
        if (sent) begin
            rx_q.push_back(data_tx);
            sent_cnt <= sent_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_sent(input int n, input int budget, output bit ok);
        int target;
        target = sent_cnt + n;
        for (int i = 0; i < budget; i++) begin
            if (sent_cnt >= target) break;
            tick();
        end
        ok = (sent_cnt >= target);
    endtask

    task automatic wait_pulse(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (sent) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit         ok;
        bit         stable;
        int         bad;
        int         base;
        logic [7:0] v;

        // reset state
        rst = 1'b0;
        tick(); tick();
        chk("rst_str", str_tx, 1'b0);
        chk("rst_data", data_tx, 8'h00);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_count", count, 5'd0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_sent", sent, 1'b0);
        rst = 1'b1;
        en  = 1'b1;
        tick();

        // single byte 0x41
        rx_q.delete();
        wr(8'h41);
        chk("one_count", count, 5'd1);
        chk("one_empty", empty, 1'b0);
        chk("one_str_pre", str_tx, 1'b0);
        tick();
        chk("one_str", str_tx, 1'b1);
        chk("one_data", data_tx, 8'h41);
        stable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (data_tx !== 8'h41) stable = 1'b0;
            if (sent) begin
                ok = 1'b1;
                break;
            end
        end
        chk("one_sent_seen", ok, 1'b1);
        chk("one_data_stable", stable, 1'b1);
        chk("one_rel_str", str_tx, 1'b0);
        tick();
        chk("one_sent_pulse", sent, 1'b0);
        chk("one_empty_after", empty, 1'b1);
        tick(); tick();
        chk("one_sent_cnt", rx_q.size(), 1);

        // fill 16, drop 17th
        rx_q.delete();
        for (int i = 1; i <= 16; i++) wr(8'(i));
        chk("fill_full", full, 1'b1);
        chk("fill_count", count, 5'd16);
        chk("fill_ovf0", ovf, 1'b0);
        wr(8'hFF);
        chk("drop_ovf", ovf, 1'b1);
        chk("drop_count", count, 5'd16);
        wait_sent(16, 1500, ok);
        chk("fill_drain", ok, 1'b1);
        tick(); tick(); tick();
        chk("fill_rx_size", rx_q.size(), 16);
        bad = 0;
        for (int i = 0; i < 16 && i < rx_q.size(); i++)
            if (rx_q[i] !== 8'(i + 1)) bad++;
        chk("fill_order", bad, 0);
        chk("fill_empty", empty, 1'b1);

        // clear overflow
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", ovf, 1'b0);

        // full with simultaneous pop: write dropped
        rx_q.delete();
        for (int i = 0; i < 16; i++) wr(8'hA0 + 8'(i));
        wait_pulse(200, ok);
        chk("fp_rel_seen", ok, 1'b1);
        chk("fp_count_rel", count, 5'd16);
        wr(8'hAA);
        chk("fp_count", count, 5'd15);
        chk("fp_ovf", ovf, 1'b1);
        chk("fp_full", full, 1'b0);
        wait_sent(15, 1500, ok);
        chk("fp_drain", ok, 1'b1);
        tick(); tick(); tick();
        chk("fp_rx_size", rx_q.size(), 16);
        if (rx_q.size() == 16) chk("fp_last", rx_q[15], 8'hAF);

        // five entries with simultaneous write and pop
        rx_q.delete();
        for (int i = 0; i < 5; i++) wr(8'hB0 + 8'(i));
        wait_pulse(200, ok);
        chk("c5_rel_seen", ok, 1'b1);
        chk("c5_count_rel", count, 5'd5);
        wr(8'hBB);
        chk("c5_count", count, 5'd5);
        wait_sent(5, 600, ok);
        chk("c5_drain", ok, 1'b1);
        tick(); tick(); tick();
        chk("c5_rx_size", rx_q.size(), 6);
        if (rx_q.size() == 6) chk("c5_last", rx_q[5], 8'hBB);

        // pointer wrap: 40 bytes in batches of 8
        rx_q.delete();
        ok = 1'b1;
        for (int b = 0; b < 5; b++) begin
            bit okb;
            for (int i = 0; i < 8; i++) wr(8'((b * 8 + i) * 37 + 5));
            wait_sent(8, 800, okb);
            if (!okb) ok = 1'b0;
        end
        chk("wrap_drain", ok, 1'b1);
        tick(); tick(); tick();
        chk("wrap_rx_size", rx_q.size(), 40);
        bad = 0;
        for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
            v = 8'(i * 37 + 5);
            if (rx_q[i] !== v) bad++;
        end
        chk("wrap_order", bad, 0);

        // disable mid-byte with 3 queued
        rx_q.delete();
        wr(8'hC1); wr(8'hC2); wr(8'hC3);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("dis_busy_seen", ok, 1'b1);
        tick(); tick();
        base = sent_cnt;
        en = 1'b0;
        tick();
        chk("dis_str", str_tx, 1'b0);
        chk("dis_count", count, 5'd0);
        chk("dis_empty", empty, 1'b1);
        chk("dis_sent", sent, 1'b0);
        chk("dis_ovf_kept", ovf, 1'b1);
        wr(8'h99);
        chk("dis_wr_ignored", count, 5'd0);
        tick(); tick();
        chk("dis_no_pulse", sent_cnt, base);
        en = 1'b1;
        tick();
        wr(8'h55);
        wait_pulse(200, ok);
        chk("reen_sent", ok, 1'b1);
        chk("reen_data", data_tx, 8'h55);
        tick(); tick();
        chk("reen_rx_size", rx_q.size(), 1);

        // reset during REQ
        wr(8'h66);
        tick();
        chk("req_str", str_tx, 1'b1);
        rst = 1'b0;
        tick();
        chk("mid_rst_str", str_tx, 1'b0);
        chk("mid_rst_data", data_tx, 8'h00);
        chk("mid_rst_empty", empty, 1'b1);
        chk("mid_rst_full", full, 1'b0);
        chk("mid_rst_count", count, 5'd0);
        chk("mid_rst_ovf", ovf, 1'b0);
        chk("mid_rst_sent", sent, 1'b0);
        rst = 1'b1;
        tick();

        // clear coincident with overflow: set wins
        for (int i = 0; i < 16; i++) wr(8'hD0 + 8'(i));
        chk("co_full", full, 1'b1);
        ovf_clr = 1'b1;
        wr(8'hEE);
        ovf_clr = 1'b0;
        chk("co_ovf", ovf, 1'b1);
        en = 1'b0;
        tick();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of byte entries; power of two, minimum 2.
REQ-002 SHALL have parameter AW, default 4, meaning log2(DEPTH).
REQ-003 SHALL have port i_clk, input, 1, meaning the single system clock.
REQ-004 SHALL have port i_rst, input, 1, meaning synchronous active-low reset.
REQ-005 SHALL have port i_en, input, 1, meaning UART enable; the same signal drives the UART's i_en.
REQ-006 SHALL have port i_wr_en, input, 1, meaning a single-cycle write strobe from the CPU bus.
REQ-007 SHALL have port i_wr_data, input, 8, meaning the byte to enqueue.
REQ-008 SHALL have port i_ovf_clr, input, 1, meaning clear the sticky overflow flag.
REQ-009 SHALL have port i_busy_tx, input, 1, meaning the UART o_busy_tx.
REQ-010 SHALL have port o_str_tx, output, 1, meaning the transmit request to UART i_str_tx.
REQ-011 SHALL have port o_data_tx, output, 8, meaning the byte to UART i_data_tx.
REQ-012 SHALL have port o_full, output, 1, meaning the queue holds DEPTH entries.
REQ-013 SHALL have port o_empty, output, 1, meaning the queue holds 0 entries.
REQ-014 SHALL have port o_count, output, AW+1, meaning the current number of entries.
REQ-015 SHALL have port o_ovf, output, 1, meaning a sticky flag set when a write is dropped.
REQ-016 SHALL have port o_sent, output, 1, meaning a one-cycle pulse per byte completed.

Function
REQ-017 SHALL implement a circular FIFO: write pointer wp, read pointer rp, and count cnt; pointers are AW bits wide and wrap from DEPTH-1 to 0.
REQ-018 SHALL enqueue i_wr_data at wp when i_wr_en=1 and o_full=0; the value is readable at the head on the next cycle.
REQ-019 SHALL drop a write issued while o_full=1 (full is registered, even if a pop occurs in the same cycle) and set o_ovf=1.
REQ-020 SHALL keep o_ovf set until i_ovf_clr=1; if a clear and a new overflow occur in the same cycle, the set wins.
REQ-021 SHALL leave cnt unchanged on a simultaneous accepted write and pop; o_full and o_empty are registered and consistent with cnt.
REQ-022 SHALL implement a feeder FSM with states IDLE, REQ, BUSY, REL, GAP.
REQ-023 In IDLE with cnt>0: SHALL load o_data_tx from the head entry, assert o_str_tx, and go to REQ.
REQ-024 In REQ: SHALL hold o_str_tx=1 and go to BUSY on the first cycle i_busy_tx=1.
REQ-025 In BUSY: SHALL hold o_str_tx=1 and go to REL on the first cycle i_busy_tx=0.
REQ-026 In REL: SHALL drive o_str_tx=0, pop the head (rp+1, cnt-1), pulse o_sent=1 for this cycle only, and go to GAP.
REQ-027 In GAP: SHALL hold o_str_tx=0 for one cycle, then go to IDLE; this allows the UART to leave its done state before the next request.
REQ-028 SHALL hold o_data_tx constant from entry to REQ until exit from REL.
REQ-029 SHALL pop exactly one entry per REQ->REL sequence; the head entry is never popped before the UART has released busy.
REQ-030 Back-to-back throughput: the next byte's REQ SHALL begin 2 cycles after REL.
REQ-031 With i_en=0: SHALL flush the queue (wp=rp=cnt=0), force the FSM to IDLE, drive o_str_tx=0, and ignore writes; o_ovf is retained.
REQ-032 On deassertion of i_en mid-byte: the byte in flight SHALL be discarded with no o_sent pulse.

Reset
REQ-033 On i_rst=0 at a rising edge of i_clk: the FSM SHALL be in IDLE, wp=rp=cnt=0, o_str_tx=0, o_data_tx=8'h00, o_empty=1, o_full=0, o_count=0, o_ovf=0, o_sent=0.
REQ-034 Reset SHALL take priority over i_en and i_wr_en; a reset mid-byte aborts the transfer, with the same outputs as REQ-033.
REQ-035 Storage array contents SHALL NOT require reset.

Structure
REQ-036 The feeder FSM state encodings SHALL live in a shared package next to the UART register-field constants (EN, STRTX, TBUSY, RXNE bit positions).
REQ-037 SHALL contain one sub-module, sync_fifo (parameterised width/depth, with push/pop/full/empty/count); the feeder FSM sits at the top level.
REQ-038 All outputs SHALL be registered except o_count, which may be a direct copy of cnt.

Verification
REQ-039 Write 8'h41 with a UART model (busy for 20 cycles) -> o_str_tx rises one cycle after the head is valid, o_data_tx=8'h41 stable until REL, one o_sent pulse, o_empty=1 afterwards.
REQ-040 Write 8'h01..8'h10 (16 bytes) in consecutive cycles -> o_full=1 after the 16th write; a 17th write of 8'hFF is dropped and o_ovf=1; the transmitted sequence is 01..10 in order, with no FF.
REQ-041 With cnt=16 (full), issue a write and a pop in the same cycle -> the write is dropped, o_ovf=1, cnt=15; in another cycle with cnt=5, issue a write and a pop together -> cnt stays 5.
REQ-042 Run pointer wrap: 40 bytes trickled through the queue -> output order matches input order across wp/rp wrap.
REQ-043 Drop i_en in BUSY with 3 entries queued -> next cycle o_str_tx=0, cnt=0, no o_sent pulse; after re-enable, a new write of 8'h55 transmits normally.
REQ-044 Assert i_rst=0 during REQ -> next cycle all outputs match REQ-033; i_ovf_clr pulsed at the same cycle as an overflow -> o_ovf stays 1.
